// File: rtl/aabb_hit_scheduler_if.sv
// Shared types and the scheduler's bus interface. The slave modport is the scheduler.
// The master modport is its surroundings: the dispatcher, the primitive table, AABBHit and the consumer.
`ifndef AABB_PRIM_INDEX_DEFS
`define AABB_PRIM_INDEX_DEFS
`define PRIMITIVE_INDEX aabb_types_pkg::prim_index_t
`define NULL_PRIMITIVE_INDEX aabb_types_pkg::NULL_PI
`endif

package aabb_types_pkg;
    // Fixed is signed Q8.8.
    typedef logic signed [15:0] Fixed;
    typedef logic [7:0]         prim_index_t;

    typedef struct packed { Fixed x; Fixed y; Fixed z; } Vec3;
    typedef struct packed { Vec3 orig; Vec3 dir; prim_index_t PI; } Ray;
    typedef struct packed { Vec3 vmin; Vec3 vmax; } AABB;
    typedef struct packed { logic [7:0] r; logic [7:0] g; logic [7:0] b; } RGB8;
    typedef enum logic [1:0] {ST_DIFFUSE, ST_MIRROR, ST_GLASS, ST_EMISSIVE} SurfaceType;
    typedef struct packed {
        logic        bHit;
        Fixed        T;
        prim_index_t PI;
        RGB8         color;
        SurfaceType  st;
    } HitData;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} sched_state_t;

    localparam prim_index_t NULL_PI  = 8'hFF;
    localparam HitData      NULL_HIT = '{bHit: 1'b0, T: '0, PI: 8'hFF, color: '0, st: ST_DIFFUSE};
endpackage

interface aabb_hit_scheduler_if #(parameter int ADDR_W = 4);
    import aabb_types_pkg::*;

    // Both handshakes transfer on a rising edge where valid && ready. Once valid is raised,
    // the payload is held stable until that edge.
    logic                ray_valid;
    logic                ray_ready;
    Ray                  ray;
    logic [ADDR_W:0]     prim_count;
    logic                shadow;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    AABB                 mem_aabb;
    RGB8                 mem_color;
    SurfaceType          mem_st;
    Ray                  hu_ray;
    AABB                 hu_aabb;
    RGB8                 hu_color;
    `PRIMITIVE_INDEX     hu_pi;
    SurfaceType          hu_st;
    HitData              hu_hit;
    logic                res_valid;
    logic                res_ready;
    HitData              res_hit;
    logic                busy;
    sched_state_t        dbg_state;

    modport slave (
        input  ray_valid, ray, prim_count, shadow, mem_aabb, mem_color, mem_st, hu_hit, res_ready,
        output ray_ready, mem_rd, mem_addr, hu_ray, hu_aabb, hu_color, hu_pi, hu_st,
               res_valid, res_hit, busy, dbg_state
    );
    modport master (
        output ray_valid, ray, prim_count, shadow, mem_aabb, mem_color, mem_st, hu_hit, res_ready,
        input  ray_ready, mem_rd, mem_addr, hu_ray, hu_aabb, hu_color, hu_pi, hu_st,
               res_valid, res_hit, busy, dbg_state
    );
endinterface

// File: rtl/aabb_hit_scheduler.sv
// Scans one ray against the primitive table, one primitive per cycle, and keeps the closest hit.
// Optional macro AABB_SCHED_ANY_HIT_EN: a shadow ray stops at its first hit.
module aabb_hit_scheduler
    import aabb_types_pkg::*;
#(
    parameter int NUM_PRIMS = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    aabb_hit_scheduler_if.slave   bus
);

`ifdef AABB_SCHED_ANY_HIT_EN
    localparam bit ANY_HIT_EN = 1'b1;
`else
    localparam bit ANY_HIT_EN = 1'b0;
`endif
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(NUM_PRIMS);

    sched_state_t        r_state;
    Ray                  r_ray;
    logic                r_shadow;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_a1;
    logic                r_rd;
    logic                r_v1;
    logic                r_v2;
    logic                r_ray_ready;
    logic                r_res_valid;
    logic                r_busy;
    HitData              r_best;
    AABB                 r_aabb;
    RGB8                 r_color;
    SurfaceType          r_st;
    prim_index_t         r_pi;

    logic [ADDR_W:0]     w_cnt_in;
    logic                w_last;
    logic                w_better;
    logic                w_any_stop;

    assign w_cnt_in   = (bus.prim_count > MAX_CNT) ? MAX_CNT : bus.prim_count;
    assign w_last     = ({1'b0, r_addr} == (r_count - (ADDR_W+1)'(1)));
    // Strict less-than keeps the lower index on equal T.
    assign w_better   = r_v2 && bus.hu_hit.bHit && (!r_best.bHit || (bus.hu_hit.T < r_best.T));
    assign w_any_stop = ANY_HIT_EN && r_shadow && r_v2 && bus.hu_hit.bHit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_ray       <= '0;
            r_shadow    <= 1'b0;
            r_count     <= '0;
            r_addr      <= '0;
            r_a1        <= '0;
            r_rd        <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_ray_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_best      <= NULL_HIT;
            r_aabb      <= '0;
            r_color     <= '0;
            r_st        <= ST_DIFFUSE;
            r_pi        <= NULL_PI;
        end else begin
            // v1: table data is on mem_* this cycle; v2: hu_* holds a primitive for AABBHit.
            r_v1 <= r_rd;
            r_a1 <= r_addr;
            r_v2 <= r_v1;
            if (r_v1) begin
                r_aabb  <= bus.mem_aabb;
                r_color <= bus.mem_color;
                r_st    <= bus.mem_st;
                r_pi    <= prim_index_t'(r_a1);
            end
            if (w_better) r_best <= bus.hu_hit;

            case (r_state)
                S_IDLE: begin
                    if (bus.ray_valid) begin
                        r_ray       <= bus.ray;
                        r_shadow    <= bus.shadow;
                        r_count     <= w_cnt_in;
                        r_best      <= NULL_HIT;
                        r_addr      <= '0;
                        r_ray_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_cnt_in == '0) begin
                            r_state     <= S_DONE;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                            r_rd    <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_rd    <= 1'b0;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // With v1 clear, the last primitive is compared on this edge, so best is final.
                    if (!r_v1) begin
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_ray_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_any_stop) begin
                r_best      <= bus.hu_hit;
                r_rd        <= 1'b0;
                r_v1        <= 1'b0;
                r_v2        <= 1'b0;
                r_state     <= S_DONE;
                r_res_valid <= 1'b1;
            end
        end
    end

    assign bus.ray_ready = r_ray_ready;
    assign bus.mem_rd    = r_rd;
    assign bus.mem_addr  = r_addr;
    assign bus.hu_ray    = r_ray;
    assign bus.hu_aabb   = r_aabb;
    assign bus.hu_color  = r_color;
    assign bus.hu_pi     = r_pi;
    assign bus.hu_st     = r_st;
    assign bus.res_valid = r_res_valid;
    assign bus.res_hit   = r_best;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_aabb_hit_scheduler.sv
// Bench for aabb_hit_scheduler: synchronous table model, AABBHit stand-in and a loop-based reference.
module tb_aabb_hit_scheduler;
    import aabb_types_pkg::*;

    localparam int NP = 16;
    localparam int AW = 4;
`ifdef AABB_SCHED_ANY_HIT_EN
    localparam bit ANY_EN = 1'b1;
`else
    localparam bit ANY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    aabb_hit_scheduler_if #(.ADDR_W(AW)) bus();
    aabb_hit_scheduler #(.NUM_PRIMS(NP), .ADDR_W(AW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    int checks = 0;
    int errors = 0;

    AABB        tbl_aabb [NP];
    RGB8        tbl_color[NP];
    SurfaceType tbl_st   [NP];
    logic       tbl_hit  [NP];
    Fixed       tbl_t    [NP];
    Ray         cur_ray;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] got_q[$];

    // Table answers one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_aabb  <= tbl_aabb[bus.mem_addr];
            bus.mem_color <= tbl_color[bus.mem_addr];
            bus.mem_st    <= tbl_st[bus.mem_addr];
        end
    end

    // AABBHit stand-in: reports a hit only if the primitive's box and the current ray arrived intact.
    always_comb begin
        bus.hu_hit = NULL_HIT;
        if (bus.hu_pi < NP) begin
            if (bus.hu_aabb == tbl_aabb[bus.hu_pi[AW-1:0]] && bus.hu_ray == cur_ray) begin
                bus.hu_hit.bHit  = tbl_hit[bus.hu_pi[AW-1:0]];
                bus.hu_hit.T     = tbl_t[bus.hu_pi[AW-1:0]];
                bus.hu_hit.PI    = bus.hu_pi;
                bus.hu_hit.color = bus.hu_color;
                bus.hu_hit.st    = bus.hu_st;
            end
        end
    end

    task automatic fill_table(input int hit_pct);
        logic [127:0] r;
        logic [23:0]  c;
        for (int i = 0; i < NP; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            c = 24'($urandom);
            tbl_aabb[i]  = r[$bits(AABB)-1:0];
            tbl_color[i] = c;
            tbl_st[i]    = SurfaceType'($urandom_range(0, 3));
            tbl_hit[i]   = ($urandom_range(0, 99) < hit_pct);
            tbl_t[i]     = Fixed'($urandom_range(0, 65535));
        end
    endtask

    // Walk the primitives in order, keep the strictly smaller T; an any-hit shadow ray stops at the first.
    task automatic ref_model(input int pc, input bit shd, output HitData h, output int lat, output int nrd);
        int n;
        bit any;
        n   = (pc > NP) ? NP : pc;
        any = shd && ANY_EN;
        h   = NULL_HIT;
        lat = (n == 0) ? 1 : n + 3;
        nrd = n;
        for (int i = 0; i < n; i++) begin
            if (tbl_hit[i] && (!h.bHit || tbl_t[i] < h.T)) begin
                h.bHit  = 1'b1;
                h.T     = tbl_t[i];
                h.PI    = prim_index_t'(i);
                h.color = tbl_color[i];
                h.st    = tbl_st[i];
                if (any) begin
                    lat = i + 4;
                    nrd = (i + 3 < n) ? i + 3 : n;
                    break;
                end
            end
        end
    endtask

    // Leaves the bench at a falling edge inside the first cycle with res_valid (lat = -1 on timeout).
    task automatic run_ray(input int pc, input bit shd, output int lat, output int nrd,
                           output int first_rd, output int last_rd, output HitData res);
        logic [127:0] r;
        got_q.delete();
        lat = -1; nrd = 0; first_rd = -1; last_rd = -1; res = NULL_HIT;
        for (int w = 0; w < 20 && !bus.ray_ready; w++) @(negedge clk);
        r = {$urandom, $urandom, $urandom, $urandom};
        cur_ray        = r[$bits(Ray)-1:0];
        bus.ray        = cur_ray;
        bus.prim_count = (AW+1)'(pc);
        bus.shadow     = shd;
        bus.ray_valid  = 1'b1;
        @(negedge clk);
        bus.ray_valid  = 1'b0;
        bus.ray        = ~cur_ray;
        for (int c = 1; c < 200; c++) begin
            if (bus.mem_rd) begin
                nrd++;
                got_q.push_back(bus.mem_addr);
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            if (bus.res_valid) begin
                lat = c;
                res = bus.res_hit;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic finish_ray();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.ray_valid = 1'b0; bus.res_ready = 1'b0; bus.shadow = 1'b0;
        bus.prim_count = '0; bus.ray = '0; cur_ray = '0;
        fill_table(0);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ray_ready !== 1'b1) begin errors++; $display("FAIL reset ray_ready: got %b want 1", bus.ray_ready); end
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset mem_rd: got %b want 0", bus.mem_rd); end
        checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset mem_addr: got %0d want 0", bus.mem_addr); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset res_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        checks++; if (bus.res_hit.bHit !== 1'b0) begin errors++; $display("FAIL reset bHit: got %b want 0", bus.res_hit.bHit); end
        checks++; if (bus.res_hit.PI !== NULL_PI) begin errors++; $display("FAIL reset res PI: got %0h want %0h", bus.res_hit.PI, NULL_PI); end
        checks++; if (bus.hu_pi !== NULL_PI) begin errors++; $display("FAIL reset hu_pi: got %0h want %0h", bus.hu_pi, NULL_PI); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_closest_hit();
        HitData res, exp_h; int lat, nrd, f, l, elat, enrd;
        fill_table(0);
        tbl_hit[1] = 1'b1; tbl_t[1] = 16'sh0500;
        tbl_hit[3] = 1'b1; tbl_t[3] = 16'sh0200;
        ref_model(4, 1'b0, exp_h, elat, enrd);
        run_ray(4, 1'b0, lat, nrd, f, l, res);
        checks++; if (lat !== 7) begin errors++; $display("FAIL closest latency: got %0d want 7", lat); end
        checks++; if (f !== 1 || l !== 4 || nrd !== 4) begin errors++; $display("FAIL closest mem_rd window: got %0d..%0d n=%0d want 1..4 n=4", f, l, nrd); end
        checks++; if (res.PI !== 8'd3 || res.T !== 16'sh0200 || res.bHit !== 1'b1) begin errors++; $display("FAIL closest result: got PI=%0d T=%0h b=%b want PI=3 T=200 b=1", res.PI, res.T, res.bHit); end
        checks++; if (res !== exp_h) begin errors++; $display("FAIL closest full hit: got %h want %h", res, exp_h); end
        finish_ray();
    endtask

    task automatic test_zero_and_clamp();
        HitData res, exp_h; int lat, nrd, f, l, elat, enrd;
        fill_table(40);
        run_ray(0, 1'b0, lat, nrd, f, l, res);
        checks++; if (lat !== 1) begin errors++; $display("FAIL zero latency: got %0d want 1", lat); end
        checks++; if (nrd !== 0) begin errors++; $display("FAIL zero reads: got %0d want 0", nrd); end
        checks++; if (res.bHit !== 1'b0 || res.PI !== NULL_PI) begin errors++; $display("FAIL zero result: got b=%b PI=%0h want b=0 PI=ff", res.bHit, res.PI); end
        finish_ray();
        ref_model(20, 1'b0, exp_h, elat, enrd);
        run_ray(20, 1'b0, lat, nrd, f, l, res);
        checks++; if (nrd !== 16 || lat !== 19) begin errors++; $display("FAIL clamp reads/latency: got %0d/%0d want 16/19", nrd, lat); end
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(AW'(i));
        for (int i = 0; i < 16 && got_q.size() > 0; i++) begin
            logic [AW-1:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL clamp address: got %0d want %0d", g, e); end
        end
        checks++; if (res !== exp_h) begin errors++; $display("FAIL clamp hit: got %h want %h", res, exp_h); end
        finish_ray();
    endtask

    task automatic test_tie();
        HitData res; int lat, nrd, f, l;
        fill_table(0);
        tbl_hit[0] = 1'b1; tbl_t[0] = 16'sh0300;
        tbl_hit[1] = 1'b0; tbl_t[1] = -16'sh0400;
        tbl_hit[2] = 1'b1; tbl_t[2] = 16'sh0300;
        run_ray(3, 1'b0, lat, nrd, f, l, res);
        checks++; if (res.PI !== 8'd0 || res.T !== 16'sh0300 || res.bHit !== 1'b1) begin errors++; $display("FAIL tie result: got PI=%0d T=%0h b=%b want PI=0 T=300 b=1", res.PI, res.T, res.bHit); end
        checks++; if (res.color !== tbl_color[0]) begin errors++; $display("FAIL tie colour: got %h want %h", res.color, tbl_color[0]); end
        finish_ray();
    endtask

    task automatic test_back_to_back();
        HitData res, hold; int lat, nrd, f, l;
        fill_table(50);
        run_ray(2, 1'b0, lat, nrd, f, l, res);
        hold = bus.res_hit;
        bus.ray = ~cur_ray; bus.prim_count = (AW+1)'(3); bus.ray_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.res_valid !== 1'b1 || bus.ray_ready !== 1'b0) begin errors++; $display("FAIL stall flags: got valid=%b ready=%b want 1/0", bus.res_valid, bus.ray_ready); end
            checks++; if (bus.res_hit !== hold) begin errors++; $display("FAIL stall hit stable: got %h want %h", bus.res_hit, hold); end
        end
        bus.ray_valid = 1'b0;
        finish_ray();
        checks++; if (bus.ray_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.mem_rd !== 1'b0) begin
            errors++; $display("FAIL after handshake: got ready=%b busy=%b valid=%b rd=%b want 1/0/0/0", bus.ray_ready, bus.busy, bus.res_valid, bus.mem_rd);
        end
    endtask

    task automatic test_reset_mid_scan();
        HitData res, exp_h; int lat, nrd, f, l, elat, enrd;
        fill_table(40);
        bus.ray = '1; bus.prim_count = (AW+1)'(8); bus.shadow = 1'b0; bus.ray_valid = 1'b1;
        @(negedge clk);
        bus.ray_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0 || bus.mem_addr !== '0 || bus.ray_ready !== 1'b1) begin
            errors++; $display("FAIL mid reset ctrl: got busy=%b rd=%b addr=%0d ready=%b want 0/0/0/1", bus.busy, bus.mem_rd, bus.mem_addr, bus.ray_ready);
        end
        checks++; if (bus.res_valid !== 1'b0 || bus.hu_pi !== NULL_PI || bus.res_hit.PI !== NULL_PI) begin
            errors++; $display("FAIL mid reset data: got valid=%b hu_pi=%0h pi=%0h want 0/ff/ff", bus.res_valid, bus.hu_pi, bus.res_hit.PI);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        ref_model(8, 1'b0, exp_h, elat, enrd);
        run_ray(8, 1'b0, lat, nrd, f, l, res);
        checks++; if (lat !== elat || nrd !== 8) begin errors++; $display("FAIL after reset timing: got lat=%0d n=%0d want %0d/8", lat, nrd, elat); end
        checks++; if (res !== exp_h) begin errors++; $display("FAIL after reset hit: got %h want %h", res, exp_h); end
        finish_ray();
    endtask

    task automatic test_any_hit();
        HitData res, exp_h; int lat, nrd, f, l, elat, enrd;
        fill_table(0);
        tbl_hit[2] = 1'b1; tbl_t[2] = 16'sh0400;
        tbl_hit[4] = 1'b1; tbl_t[4] = 16'sh0100;
        ref_model(8, 1'b1, exp_h, elat, enrd);
        run_ray(8, 1'b1, lat, nrd, f, l, res);
        checks++; if (lat !== elat) begin errors++; $display("FAIL shadow latency: got %0d want %0d", lat, elat); end
        checks++; if (nrd !== enrd || f !== 1 || l !== enrd) begin errors++; $display("FAIL shadow reads: got %0d..%0d n=%0d want 1..%0d", f, l, nrd, enrd); end
        checks++; if (res !== exp_h) begin errors++; $display("FAIL shadow hit: got PI=%0d T=%0h want PI=%0d T=%0h", res.PI, res.T, exp_h.PI, exp_h.T); end
        finish_ray();
    endtask

    task automatic test_random();
        HitData res, exp_h; int lat, nrd, f, l, elat, enrd, pc; bit shd;
        for (int t = 0; t < 20; t++) begin
            fill_table($urandom_range(0, 60));
            pc  = $urandom_range(0, 20);
            shd = 1'($urandom_range(0, 1));
            ref_model(pc, shd, exp_h, elat, enrd);
            run_ray(pc, shd, lat, nrd, f, l, res);
            checks++; if (lat !== elat || nrd !== enrd) begin errors++; $display("FAIL random %0d timing: got lat=%0d n=%0d want %0d/%0d", t, lat, nrd, elat, enrd); end
            checks++; if (res !== exp_h) begin errors++; $display("FAIL random %0d hit: got %h want %h", t, res, exp_h); end
            for (int i = 0; i < nrd && got_q.size() > 0; i++) begin
                logic [AW-1:0] g;
                g = got_q.pop_front();
                checks++; if (g !== AW'(i)) begin errors++; $display("FAIL random %0d address: got %0d want %0d", t, g, i); end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            finish_ray();
        end
    endtask

    initial begin
        test_reset();
        test_closest_hit();
        test_zero_and_clamp();
        test_tie();
        test_back_to_back();
        test_reset_mid_scan();
        test_any_hit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
